pc_sequencer: RTL and testbench

Sequencing controller for the PC-source selection path of the multicycle core. Every cycle it turns the control-transfer requests from the main control unit into the 4-bit PC source select and the PC write enable. It also runs the multi-cycle exception entry: it saves EPC, reads the exception vector byte from memory and loads the sign-extended vector into PC. Sits between the main control FSM and the PC, EPC and memory-address path.

---
 rtl/pc_seq_pkg.sv | 36 +++
 rtl/exc_wait_counter.sv | 31 +++
 rtl/pc_sequencer.sv | 153 +++++++++++++++
 tb/tb_pc_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared encodings for the PC-source sequencer: mux selects, exception causes,
// FSM states and the wait-counter sizing helper.
package pc_seq_pkg;

  typedef enum logic [3:0] {
    PCSRC_ALU     = 4'd0,
    PCSRC_ALUOUT  = 4'd1,
    PCSRC_SHIFT28 = 4'd2,
    PCSRC_EPC     = 4'd3,
    PCSRC_SIGN8   = 4'd4
  } pcsrc_e;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_OPCODE = 2'd1,
    CAUSE_OVF    = 2'd2,
    CAUSE_DIV0   = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXC_SAVE = 2'd1,
    ST_EXC_WAIT = 2'd2,
    ST_EXC_LOAD = 2'd3
  } state_e;

  localparam int unsigned ADDR_W = 32;

  // Counter must hold MEM_LAT-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned lat);
    int unsigned w;
    w = $clog2(lat);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/exc_wait_counter.sv
// Loadable down-counter that times the memory latency of the vector byte read.
module exc_wait_counter
  import pc_seq_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int unsigned CNT_W = cnt_width(MEM_LAT);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pc_sequencer.sv
// PC-source sequencer: zero-latency decode of control transfers in IDLE and a
// multi-cycle exception entry (save EPC, fetch vector byte, load PC).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned VEC_OPCODE = 253,
  parameter int unsigned VEC_OVF    = 254,
  parameter int unsigned VEC_DIV0   = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              seq_req,
  input  logic              branch_req,
  input  logic              branch_taken,
  input  logic              jump_req,
  input  logic              jr_req,
  input  logic              rte_req,
  input  logic              exc_opcode,
  input  logic              exc_ovf,
  input  logic              exc_div0,
  output logic [3:0]        pcsource,
  output logic              pc_write,
  output logic              epc_write,
  output logic              exc_mem_read,
  output logic [ADDR_W-1:0] exc_addr,
  output logic [1:0]        exc_cause,
  output logic              busy
);

  state_e            state_q, state_d;
  pcsrc_e            pcsource_c;
  logic              pc_write_c;
  logic              exc_take_c;
  cause_e            cause_c;
  logic [ADDR_W-1:0] vec_addr_c;
  logic              cnt_load_c;
  logic              cnt_dec_c;
  logic              cnt_zero;
  cause_e            cause_q;
  logic [ADDR_W-1:0] addr_q;

  exc_wait_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_wait_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (cnt_load_c),
    .dec     (cnt_dec_c),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Cause and vector address are captured only when an exception is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_q <= CAUSE_NONE;
      addr_q  <= '0;
    end else if (exc_take_c) begin
      cause_q <= cause_c;
      addr_q  <= vec_addr_c;
    end
  end

  always_comb begin
    state_d      = state_q;
    pcsource_c   = PCSRC_ALU;
    pc_write_c   = 1'b0;
    epc_write    = 1'b0;
    exc_mem_read = 1'b0;
    busy         = 1'b0;
    cnt_load_c   = 1'b0;
    cnt_dec_c    = 1'b0;
    exc_take_c   = 1'b0;
    cause_c      = CAUSE_NONE;
    vec_addr_c   = '0;

    case (state_q)
      ST_IDLE: begin
        // Fixed priority; lower-priority requests in the same cycle are dropped.
        if (exc_opcode) begin
          exc_take_c = 1'b1;
          cause_c    = CAUSE_OPCODE;
          vec_addr_c = ADDR_W'(VEC_OPCODE);
        end else if (exc_div0) begin
          exc_take_c = 1'b1;
          cause_c    = CAUSE_DIV0;
          vec_addr_c = ADDR_W'(VEC_DIV0);
        end else if (exc_ovf) begin
          exc_take_c = 1'b1;
          cause_c    = CAUSE_OVF;
          vec_addr_c = ADDR_W'(VEC_OVF);
        end else if (rte_req) begin
          pcsource_c = PCSRC_EPC;
          pc_write_c = 1'b1;
        end else if (jr_req) begin
          pcsource_c = PCSRC_ALUOUT;
          pc_write_c = 1'b1;
        end else if (jump_req) begin
          pcsource_c = PCSRC_SHIFT28;
          pc_write_c = 1'b1;
        end else if (branch_req) begin
          pcsource_c = PCSRC_ALUOUT;
          pc_write_c = branch_taken;
        end else if (seq_req) begin
          pcsource_c = PCSRC_ALU;
          pc_write_c = 1'b1;
        end
        if (exc_take_c) begin
          state_d = ST_EXC_SAVE;
        end
      end
      ST_EXC_SAVE: begin
        busy         = 1'b1;
        epc_write    = 1'b1;
        exc_mem_read = 1'b1;
        cnt_load_c   = 1'b1;
        state_d      = ST_EXC_WAIT;
      end
      ST_EXC_WAIT: begin
        busy = 1'b1;
        if (cnt_zero) begin
          state_d = ST_EXC_LOAD;
        end else begin
          cnt_dec_c = 1'b1;
        end
      end
      ST_EXC_LOAD: begin
        busy       = 1'b1;
        pcsource_c = PCSRC_SIGN8;
        pc_write_c = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // IDLE decode is Mealy, so mask it while reset is held to keep outputs at 0.
  assign pcsource  = reset_n ? 4'(pcsource_c) : 4'd0;
  assign pc_write  = reset_n & pc_write_c;
  assign exc_cause = 2'(cause_q);
  assign exc_addr  = addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (MEM_LAT=1 and 3) share stimulus and are
// compared every cycle against a phase-count reference model.
module tb_pc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, seq_req, branch_req, branch_taken, jump_req, jr_req, rte_req;
  logic exc_opcode, exc_ovf, exc_div0;

  logic [3:0]  ps1, ps3;
  logic        pw1, pw3, ew1, ew3, mr1, mr3, bz1, bz3;
  logic [31:0] ad1, ad3;
  logic [1:0]  ca1, ca3;

  pc_sequencer #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .seq_req(seq_req), .branch_req(branch_req),
    .branch_taken(branch_taken), .jump_req(jump_req), .jr_req(jr_req),
    .rte_req(rte_req), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf),
    .exc_div0(exc_div0), .pcsource(ps1), .pc_write(pw1), .epc_write(ew1),
    .exc_mem_read(mr1), .exc_addr(ad1), .exc_cause(ca1), .busy(bz1)
  );

  pc_sequencer #(.MEM_LAT(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .seq_req(seq_req), .branch_req(branch_req),
    .branch_taken(branch_taken), .jump_req(jump_req), .jr_req(jr_req),
    .rte_req(rte_req), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf),
    .exc_div0(exc_div0), .pcsource(ps3), .pc_write(pw3), .epc_write(ew3),
    .exc_mem_read(mr3), .exc_addr(ad3), .exc_cause(ca3), .busy(bz3)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: k = cycles since exception acceptance (0 = free).
  int          mk[2];
  int          mlat[2];
  logic [1:0]  mcause[2];
  logic [31:0] maddr[2];

  task automatic chk(input string tag, input int d, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s lat%0d observed=%0h expected=%0h", tag, mlat[d], obs, exp);
    end
  endtask

  task automatic model_cycle(input int d);
    logic [3:0]  e_ps;
    logic        e_pw, e_ew, e_mr, e_bz, exc;
    logic [3:0]  o_ps;
    logic        o_pw, o_ew, o_mr, o_bz;
    logic [31:0] o_ad;
    logic [1:0]  o_ca;
    int          last;
    last = 2 + mlat[d];
    exc  = exc_opcode | exc_ovf | exc_div0;
    e_ps = 4'd0; e_pw = 1'b0; e_ew = 1'b0; e_mr = 1'b0; e_bz = 1'b0;
    if (!reset_n) begin
      mk[d] = 0; mcause[d] = 2'd0; maddr[d] = 32'd0;
    end else if (mk[d] == 0) begin
      if (!exc) begin
        if (rte_req)         begin e_ps = 4'd3; e_pw = 1'b1; end
        else if (jr_req)     begin e_ps = 4'd1; e_pw = 1'b1; end
        else if (jump_req)   begin e_ps = 4'd2; e_pw = 1'b1; end
        else if (branch_req) begin e_ps = 4'd1; e_pw = branch_taken; end
        else if (seq_req)    begin e_ps = 4'd0; e_pw = 1'b1; end
      end
    end else begin
      e_bz = 1'b1;
      e_ew = (mk[d] == 1);
      e_mr = (mk[d] == 1);
      e_pw = (mk[d] == last);
      e_ps = (mk[d] == last) ? 4'd4 : 4'd0;
    end

    if (d == 0) begin
      o_ps = ps1; o_pw = pw1; o_ew = ew1; o_mr = mr1; o_bz = bz1; o_ad = ad1; o_ca = ca1;
    end else begin
      o_ps = ps3; o_pw = pw3; o_ew = ew3; o_mr = mr3; o_bz = bz3; o_ad = ad3; o_ca = ca3;
    end
    chk("pcsource",     d, 32'(o_ps), 32'(e_ps));
    chk("pc_write",     d, 32'(o_pw), 32'(e_pw));
    chk("epc_write",    d, 32'(o_ew), 32'(e_ew));
    chk("exc_mem_read", d, 32'(o_mr), 32'(e_mr));
    chk("busy",         d, 32'(o_bz), 32'(e_bz));
    chk("exc_addr",     d, o_ad, maddr[d]);
    chk("exc_cause",    d, 32'(o_ca), 32'(mcause[d]));

    // Advance to the state seen after the next rising edge.
    if (reset_n) begin
      if (mk[d] == 0) begin
        if (exc) begin
          mk[d] = 1;
          if (exc_opcode)    begin mcause[d] = 2'd1; maddr[d] = 32'd253; end
          else if (exc_div0) begin mcause[d] = 2'd3; maddr[d] = 32'd255; end
          else               begin mcause[d] = 2'd2; maddr[d] = 32'd254; end
        end
      end else begin
        mk[d] = (mk[d] == last) ? 0 : mk[d] + 1;
      end
    end
  endtask

  // One cycle: drive at the falling edge, sample 1 ns later, well before rising edge.
  task automatic step(input logic rn, input logic s, input logic b, input logic bt,
                      input logic j, input logic jr, input logic rte,
                      input logic eo, input logic ev, input logic ed);
    @(negedge clk);
    reset_n = rn; seq_req = s; branch_req = b; branch_taken = bt; jump_req = j;
    jr_req = jr; rte_req = rte; exc_opcode = eo; exc_ovf = ev; exc_div0 = ed;
    #1;
    model_cycle(0);
    model_cycle(1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    mlat[0] = 1; mlat[1] = 3;
    for (int d = 0; d < 2; d++) begin mk[d] = 0; mcause[d] = 2'd0; maddr[d] = 32'd0; end
    reset_n = 1'b0; seq_req = 1'b0; branch_req = 1'b0; branch_taken = 1'b0;
    jump_req = 1'b0; jr_req = 1'b0; rte_req = 1'b0;
    exc_opcode = 1'b0; exc_ovf = 1'b0; exc_div0 = 1'b0;

    // Reset with a request present: outputs must stay 0.
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(1);

    // Priority among non-exception requests, then a not-taken branch.
    step(1, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    chk("prio_pcsource", 0, 32'(ps1), 32'd2);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("ntbranch_pw", 0, 32'(pw1), 32'd0);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Overflow exception, check the MEM_LAT=1 timeline explicitly.
    step(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ovf_addr", 0, ad1, 32'd254);
    chk("ovf_epc_t1", 0, 32'(ew1), 32'd1);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ovf_load_ps", 0, 32'(ps1), 32'd4);
    chk("ovf_cause", 0, 32'(ca1), 32'd2);
    idle(3);

    // div0 beats ovf; requests during EXC_WAIT are ignored.
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    step(1, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    chk("busy_ignore_pw", 0, 32'(pw1), 32'd0);
    chk("busy_ignore_addr", 0, ad1, 32'd255);
    chk("div0_cause", 0, 32'(ca1), 32'd3);
    idle(4);

    // Opcode exception on the MEM_LAT=3 instance, rte right after it finishes.
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(4);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lat3_load_ps", 1, 32'(ps3), 32'd4);
    chk("lat3_addr", 1, ad3, 32'd253);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("lat3_rte_ps", 1, 32'(ps3), 32'd3);
    chk("lat3_rte_pw", 1, 32'(pw3), 32'd1);

    // Reset in the middle of EXC_WAIT, then a sequential fetch.
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_busy", 1, 32'(bz3), 32'd0);
    chk("rst_cause", 1, 32'(ca3), 32'd0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_pw", 0, 32'(pw1), 32'd1);

    // Randomized traffic with occasional exceptions and resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 13) == 0),
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 13) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
